// File: rtl/uart_frame_pkg.sv
// Shared definitions for the `&&payload&&` string framing used by the UART string TX/RX pair.
// Holds the delimiter, the one-hot deframer states and the default string geometry.
package uart_frame_pkg;

    localparam logic [7:0]  DELIM           = 8'h26;
    localparam int unsigned MAX_LEN_DEF     = 137;
    localparam int unsigned LEN_W_DEF       = 8;
    localparam int unsigned TIMEOUT_CLK_DEF = 17360;

    typedef enum logic [5:0] {
        StIdle    = 6'b000001,
        StSof     = 6'b000010,
        StPayload = 6'b000100,
        StEof     = 6'b001000,
        StDone    = 6'b010000,
        StErr     = 6'b100000
    } state_e;

    // States in which an opening delimiter has been seen and the line may stall.
    function automatic logic in_frame(input state_e s);
        return s inside {StSof, StPayload, StEof};
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter: counts while enabled, restarts on clear, and flags expiry
// on the cycle the count reaches TIMEOUT_CLK-1.
module uart_frame_timeout #(
    parameter int unsigned TIMEOUT_CLK = 17360
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned    CNT_W = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLK - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer for `&&payload&&` strings from uart_rx into a packed string register.
// Optional inter-byte timeout is compiled in with FRAME_RX_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN     = MAX_LEN_DEF,
    parameter int unsigned LEN_W       = LEN_W_DEF,
    parameter int unsigned TIMEOUT_CLK = TIMEOUT_CLK_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_vld,
    output logic [MAX_LEN*8-1:0] frame_data,
    output logic [LEN_W-1:0]     frame_len,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 frame_err
);

    if ((MAX_LEN < 1) || ((64'd1 << LEN_W) <= 64'(MAX_LEN)) || (TIMEOUT_CLK < 2))
    begin : g_param_check
        $error("uart_frame_rx: inconsistent MAX_LEN/LEN_W/TIMEOUT_CLK");
    end

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    state_e               r_state;
    logic [LEN_W-1:0]     r_wr_cnt;
    logic [MAX_LEN*8-1:0] r_data;
    logic [LEN_W-1:0]     r_len;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic w_is_delim;
    logic w_room1;
    logic w_room2;
    logic w_expire;

    assign w_is_delim = (rx_data == DELIM);
    assign w_room1    = (r_wr_cnt < MAX_CNT);
    assign w_room2    = (r_wr_cnt < MAX_CNT - LEN_W'(1));

`ifdef FRAME_RX_TIMEOUT_EN
    uart_frame_timeout #(
        .TIMEOUT_CLK(TIMEOUT_CLK)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_clr   (rx_vld),
        .i_en    (in_frame(r_state)),
        .o_expire(w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Constant-index byte write, so the decode stays within the MAX_LEN slots.
    function automatic logic [MAX_LEN*8-1:0] put_byte(input logic [MAX_LEN*8-1:0] vec,
                                                     input logic [LEN_W-1:0]     idx,
                                                     input logic [7:0]           b);
        logic [MAX_LEN*8-1:0] res;
        res = vec;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (idx == LEN_W'(k)) res[8*k +: 8] = b;
        end
        return res;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= StIdle;
            r_wr_cnt <= '0;
            r_data   <= '0;
            r_len    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                // DONE/ERR last one cycle and treat a coincident byte like IDLE does.
                StIdle, StDone, StErr: begin
                    r_state <= (rx_vld && w_is_delim) ? StSof : StIdle;
                end
                StSof: begin
                    if (w_expire) begin
                        r_state <= StErr;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (rx_vld) begin
                        if (w_is_delim) begin
                            r_state  <= StPayload;
                            r_wr_cnt <= '0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StPayload: begin
                    if (w_expire || (rx_vld && !w_is_delim && !w_room1)) begin
                        r_state <= StErr;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (rx_vld) begin
                        if (w_is_delim) begin
                            r_state <= StEof;
                        end else begin
                            r_data   <= put_byte(r_data, r_wr_cnt, rx_data);
                            r_wr_cnt <= r_wr_cnt + LEN_W'(1);
                        end
                    end
                end
                StEof: begin
                    if (w_expire || (rx_vld && !w_is_delim && !w_room2)) begin
                        r_state <= StErr;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (rx_vld) begin
                        if (w_is_delim) begin
                            r_state <= StDone;
                            r_len   <= r_wr_cnt;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // Lone `&` was payload: store it and the current byte together.
                            r_data   <= put_byte(put_byte(r_data, r_wr_cnt, DELIM),
                                                 r_wr_cnt + LEN_W'(1), rx_data);
                            r_wr_cnt <= r_wr_cnt + LEN_W'(2);
                            r_state  <= StPayload;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_data = r_data;
    assign frame_len  = r_len;
    assign frame_busy = r_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx (MAX_LEN=4): vector table, hand-written corner
// sequences and randomized byte streams against a queue-based framing model.
module tb_uart_frame_rx;

    localparam int unsigned MAX_LEN     = 4;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned TIMEOUT_CLK = 100;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b1;
    logic [7:0]           rx_data = 8'h00;
    logic                 rx_vld  = 1'b0;
    logic [MAX_LEN*8-1:0] frame_data;
    logic [LEN_W-1:0]     frame_len;
    logic                 frame_busy;
    logic                 frame_done;
    logic                 frame_err;

    uart_frame_rx #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .TIMEOUT_CLK(TIMEOUT_CLK)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx_data   (rx_data),
        .rx_vld    (rx_vld),
        .frame_data(frame_data),
        .frame_len (frame_len),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Framing model: open/pending-& flags plus the payload as a byte queue.
    bit         m_open;
    int         m_amp;
    int         m_idle;
    logic [7:0] m_q[$];
    bit         e_done, e_err, e_busy;
    int         e_len;
    logic [7:0] e_bytes[$];

    int          obs_done, obs_err, obs_len;
    logic [31:0] obs_data;

    typedef struct {
        string       seq;
        int          n_done;
        int          n_err;
        int          len;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_close();
        m_open = 0;
        m_amp  = 0;
        m_idle = 0;
    endtask

    task automatic model_reset();
        model_close();
        m_q.delete();
        e_done = 0;
        e_err  = 0;
        e_busy = 0;
        e_len  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        e_done = 0;
        e_err  = 0;
        m_idle = 0;
        if (!m_open) begin
            if (b == 8'h26) begin
                m_amp++;
                if (m_amp == 2) begin
                    m_open = 1;
                    m_amp  = 0;
                    m_q.delete();
                end
            end else begin
                m_amp = 0;
            end
        end else if (b == 8'h26) begin
            if (m_amp == 0) begin
                m_amp = 1;
            end else begin
                e_done  = 1;
                e_len   = m_q.size();
                e_bytes = m_q;
                model_close();
            end
        end else if (m_q.size() + m_amp + 1 > int'(MAX_LEN)) begin
            e_err = 1;
            model_close();
        end else begin
            if (m_amp == 1) m_q.push_back(8'h26);
            m_q.push_back(b);
            m_amp = 0;
        end
        e_busy = m_open;
    endtask

    task automatic model_idle();
        e_done = 0;
        e_err  = 0;
`ifdef FRAME_RX_TIMEOUT_EN
        if (m_open || m_amp == 1) begin
            m_idle++;
            if (m_idle == int'(TIMEOUT_CLK)) begin
                e_err = 1;
                model_close();
                e_busy = 0;
            end
        end
`endif
    endtask

    task automatic sample_check();
        check("done", frame_done, e_done);
        check("err", frame_err, e_err);
        check("busy", frame_busy, e_busy);
        check("len", frame_len, e_len);
        if (frame_done) begin
            obs_done++;
            obs_len  = frame_len;
            obs_data = frame_data[31:0];
        end
        if (frame_err) obs_err++;
        if (e_done && frame_done) begin
            for (int i = 0; i < e_bytes.size(); i++) begin
                check("byte", frame_data[8*i +: 8], e_bytes[i]);
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge sys_clk);
        sample_check();
        rx_vld  = v;
        rx_data = d;
        if (v) model_byte(d);
        else model_idle();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sample_check();
        sys_rst = 1'b1;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        model_reset();
        repeat (3) begin
            @(negedge sys_clk);
            sample_check();
        end
        check("rst_data", frame_data, 32'h0);
        sys_rst = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i]);
            repeat (gap) step(1'b0, 8'h00);
        end
    endtask

    task automatic clear_obs();
        obs_done = 0;
        obs_err  = 0;
        obs_len  = 0;
        obs_data = 32'h0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] mask;
        int          first_err;
        int          exp_first;

        vecs[0] = '{"&&ABC&&",   1, 0, 3, 32'h00434241};
        vecs[1] = '{"&&&&",      1, 0, 0, 32'h00000000};
        vecs[2] = '{"x&y&&Z&&",  1, 0, 1, 32'h0000005A};
        vecs[3] = '{"&&a&b&&",   1, 0, 3, 32'h00622661};
        vecs[4] = '{"&&ABCDE",   0, 1, 0, 32'h00000000};
        vecs[5] = '{"&&AB&CD&&", 0, 1, 0, 32'h00000000};
        vecs[6] = '{"&&ABC&D&&", 0, 1, 0, 32'h00000000};
        vecs[7] = '{"&&ABCD&&",  1, 0, 4, 32'h44434241};
        vecs[8] = '{"&&AB&C&&",  1, 0, 4, 32'h43264241};

        model_reset();
        do_reset();

        for (int v = 0; v < 9; v++) begin
            do_reset();
            clear_obs();
            send_str(vecs[v].seq, 1);
            repeat (3) step(1'b0, 8'h00);
            check($sformatf("v%0d_ndone", v), obs_done, vecs[v].n_done);
            check($sformatf("v%0d_nerr", v), obs_err, vecs[v].n_err);
            if (vecs[v].n_done > 0) begin
                mask = (vecs[v].len >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * vecs[v].len)) - 1);
                check($sformatf("v%0d_len", v), obs_len, vecs[v].len);
                check($sformatf("v%0d_data", v), obs_data & mask, vecs[v].data);
            end
        end

        // Overflow then a fresh frame, bytes back to back.
        do_reset();
        clear_obs();
        send_str("&&ABCDE", 0);
        send_str("&&OK&&", 0);
        repeat (3) step(1'b0, 8'h00);
        check("ovf_nerr", obs_err, 1);
        check("ovf_ndone", obs_done, 1);
        check("ovf_len", obs_len, 2);
        check("ovf_data", obs_data & 32'hFFFF, 32'h4B4F);

        // Reset in the middle of a frame.
        do_reset();
        clear_obs();
        send_str("&&AB", 1);
        do_reset();
        check("midrst_quiet", obs_done + obs_err, 0);
        send_str("&&Q&&", 1);
        repeat (3) step(1'b0, 8'h00);
        check("midrst_ndone", obs_done, 1);
        check("midrst_len", obs_len, 1);
        check("midrst_byte0", obs_data & 32'hFF, 32'h51);

        // Stalled frame: timeout only when the feature is compiled in.
        do_reset();
        send_str("&&AB", 0);
        first_err = -1;
        for (int k = 1; k <= 130; k++) begin
            step(1'b0, 8'h00);
            if (frame_err && first_err < 0) first_err = k - 1;
        end
`ifdef FRAME_RX_TIMEOUT_EN
        exp_first = int'(TIMEOUT_CLK);
`else
        exp_first = -1;
`endif
        check("timeout_cycle", first_err, exp_first);

        // Random byte streams, heavy on delimiters so every boundary is exercised.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 9) < 4) step(1'b1, 8'h26);
            else step(1'b1, 8'(8'h41 + $urandom_range(0, 25)));
            repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
        end
        repeat (3) step(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
